// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 codes, memory modes,
// memory-state values, mcause codes and the FSM state encoding.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MODE_SB = 2'b00;
  localparam logic [1:0] MODE_SH = 2'b01;
  localparam logic [1:0] MODE_SW = 2'b10;

  localparam logic [1:0] MEMORY_STATE_OK = 2'b00;

  localparam logic [3:0] CAUSE_ILLEGAL_INSN     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic common;
    common = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (we) return common;
    return common || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      MODE_SB: return 1'b0;
      MODE_SH: return addr_lo[0];
      MODE_SW: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational sign/zero extension of aligned load data according to funct3.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (funct3)
      F3_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
      F3_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
      F3_BU:   data_out = {24'h0, data_in[7:0]};
      F3_HU:   data_out = {16'h0, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, checks alignment and
// funct3, drives the byte-addressable memory ports and returns an extended result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [3:0]            resp_cause,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic [1:0]            mem_r_mode,
  input  logic [31:0]           mem_r_data,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [31:0]           mem_w_data,
  output logic [1:0]            mem_w_mode,
  input  logic [1:0]            mem_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready. Once
  // raised, resp_valid and its payload hold until that transfer edge.

  localparam logic [2:0] WAIT_CYCLES = 3'(READ_LATENCY);

  lsu_state_e  state, state_next;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic        lat_err;
  logic [3:0]  lat_cause;
  logic [2:0]  wait_cnt;
  logic        accept;
  logic        acc_err;
  logic [3:0]  acc_cause;
  logic [31:0] ext_data;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    acc_err   = 1'b0;
    acc_cause = 4'd0;
    if (!funct3_legal(req_we, req_funct3)) begin
      acc_err   = 1'b1;
      acc_cause = CAUSE_ILLEGAL_INSN;
    end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
      acc_err   = 1'b1;
      acc_cause = req_we ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
    end
  end

  lsu_load_extend u_load_extend (
    .funct3   (lat_f3),
    .data_in  (mem_r_data),
    .data_out (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Rejected requests still spend their ISSUE cycle (with enables held low)
  // so the error response arrives one edge after accept.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = lat_err ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_cnt == 3'd1) state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_f3     <= 3'd0;
      lat_err    <= 1'b0;
      lat_cause  <= 4'd0;
      wait_cnt   <= 3'd0;
      mem_r_en   <= 1'b0;
      mem_r_addr <= '0;
      mem_r_mode <= 2'b00;
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= 32'd0;
      mem_w_mode <= 2'b00;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      resp_cause <= 4'd0;
    end else begin
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;

      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_err   <= acc_err;
        lat_cause <= acc_cause;
        if (!acc_err) begin
          if (req_we) begin
            mem_w_en   <= 1'b1;
            mem_w_addr <= req_addr;
            mem_w_data <= req_wdata;
            mem_w_mode <= req_funct3[1:0];
          end else begin
            mem_r_en   <= 1'b1;
            mem_r_addr <= req_addr;
            mem_r_mode <= req_funct3[1:0];
          end
        end
      end

      if (state == ST_ISSUE) begin
        wait_cnt <= WAIT_CYCLES;
        if (lat_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_cause <= lat_cause;
          resp_rdata <= 32'd0;
        end
      end

      // mem_r_addr/mem_r_mode stay untouched here: memory aligns its output from them.
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          resp_valid <= 1'b1;
          if (mem_state != MEMORY_STATE_OK) begin
            resp_err   <= 1'b1;
            resp_cause <= lat_we ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            resp_rdata <= 32'd0;
          end else begin
            resp_err   <= 1'b0;
            resp_cause <= 4'd0;
            resp_rdata <= lat_we ? 32'd0 : ext_data;
          end
        end
      end

      if ((state == ST_RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_cause <= 4'd0;
        resp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressable memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  resp_cause;
  logic        mem_r_en;
  logic [31:0] mem_r_addr;
  logic [1:0]  mem_r_mode;
  logic [31:0] mem_r_data;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [1:0]  mem_w_mode;
  logic [1:0]  mem_state = 2'b00;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  bit          mem_loaded = 1'b0;
  int          r_cnt = 0;
  int          w_cnt = 0;
  logic [1:0]  last_w_mode = 2'b11;
  logic        fault_arm = 1'b0;
  logic [31:0] shifted;

  logic [31:0] got_rdata;
  logic        got_err;
  logic [3:0]  got_cause;
  int          got_lat;

  load_store_unit #(.READ_LATENCY(1), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_cause (resp_cause),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_mode (mem_r_mode),
    .mem_r_data (mem_r_data),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_w_mode (mem_w_mode),
    .mem_state  (mem_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // memory model: aligned, zero-extended read port; byte-lane writes
  always_comb begin
    shifted = mem[mem_r_addr[9:2]] >> {mem_r_addr[1:0], 3'b000};
    case (mem_r_mode)
      2'b00:   mem_r_data = {24'h0, shifted[7:0]};
      2'b01:   mem_r_data = {16'h0, shifted[15:0]};
      default: mem_r_data = mem[mem_r_addr[9:2]];
    endcase
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h40] = 32'h80FF7F01;
      mem_loaded = 1'b1;
    end else if (mem_w_en) begin
      w_cnt++;
      last_w_mode = mem_w_mode;
      case (mem_w_mode)
        2'b00: case (mem_w_addr[1:0])
          2'd0: mem[mem_w_addr[9:2]][7:0]   = mem_w_data[7:0];
          2'd1: mem[mem_w_addr[9:2]][15:8]  = mem_w_data[7:0];
          2'd2: mem[mem_w_addr[9:2]][23:16] = mem_w_data[7:0];
          default: mem[mem_w_addr[9:2]][31:24] = mem_w_data[7:0];
        endcase
        2'b01: if (mem_w_addr[1]) mem[mem_w_addr[9:2]][31:16] = mem_w_data[15:0];
               else               mem[mem_w_addr[9:2]][15:0]  = mem_w_data[15:0];
        default: mem[mem_w_addr[9:2]] = mem_w_data;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_r_en) r_cnt++;
  end

  // fault injection: raise mem_state in the cycle after the memory samples an enable
  always @(posedge clk) begin
    if (fault_arm && (mem_r_en || mem_w_en)) begin
      #1 mem_state = 2'b01;
    end else if (!fault_arm) begin
      mem_state = 2'b00;
    end
  end

  // driver: full transaction, results captured at first resp_valid
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got_lat = 0;
    while (resp_valid !== 1'b1 && got_lat < 20) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    got_cause = resp_cause;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    total++;
    if ({resp_valid, resp_err, resp_cause, mem_r_en, mem_w_en} !== 8'd0 || resp_rdata !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: got rv=%b err=%b cause=%0d ren=%b wen=%b rdata=%h expected all 0",
                      resp_valid, resp_err, resp_cause, mem_r_en, mem_w_en, resp_rdata);
    end
    total++;
    if (mem_r_addr !== 32'd0 || mem_w_addr !== 32'd0 || mem_w_data !== 32'd0 ||
        mem_r_mode !== 2'b00 || mem_w_mode !== 2'b00) begin
      bad++; $display("FAIL reset_mem_ports: got raddr=%h waddr=%h wdata=%h expected 0",
                      mem_r_addr, mem_w_addr, mem_w_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
    logic [31:0] addrs [6] = '{32'h102, 32'h102, 32'h101, 32'h102, 32'h102, 32'h100};
    logic [31:0] exps  [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'h0000007F,
                               32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    int r0;
    for (int i = 0; i < 6; i++) begin
      r0 = r_cnt;
      issue(1'b0, f3s[i], addrs[i], 32'h0);
      total++;
      if (got_rdata !== exps[i]) begin
        bad++; $display("FAIL load_rdata[%0d]: got %h expected %h", i, got_rdata, exps[i]);
      end
      total++;
      if (got_lat !== 2) begin
        bad++; $display("FAIL load_latency[%0d]: got %0d expected 2", i, got_lat);
      end
      total++;
      if (got_err !== 1'b0 || got_cause !== 4'd0) begin
        bad++; $display("FAIL load_err[%0d]: got err=%b cause=%0d expected 0/0", i, got_err, got_cause);
      end
      total++;
      if (r_cnt - r0 !== 1) begin
        bad++; $display("FAIL load_ren_pulses[%0d]: got %0d expected 1", i, r_cnt - r0);
      end
    end
  endtask

  task automatic test_store();
    int w0;
    w0 = w_cnt;
    issue(1'b1, 3'b000, 32'h103, 32'h000000AA);
    total++;
    if (got_err !== 1'b0 || got_cause !== 4'd0 || got_rdata !== 32'd0 || got_lat !== 2) begin
      bad++; $display("FAIL store_resp: got err=%b cause=%0d rdata=%h lat=%0d expected 0/0/0/2",
                      got_err, got_cause, got_rdata, got_lat);
    end
    total++;
    if (w_cnt - w0 !== 1 || last_w_mode !== 2'b00) begin
      bad++; $display("FAIL store_wen_pulse: got pulses=%0d mode=%b expected 1/00", w_cnt - w0, last_w_mode);
    end
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    total++;
    if (got_rdata !== 32'hAAFF7F01) begin
      bad++; $display("FAIL store_readback: got %h expected aaff7f01", got_rdata);
    end
  endtask

  task automatic test_misaligned();
    int r0, w0;
    r0 = r_cnt;
    issue(1'b0, 3'b001, 32'h101, 32'h0);
    total++;
    if (got_err !== 1'b1 || got_cause !== 4'd4 || got_rdata !== 32'd0) begin
      bad++; $display("FAIL lh_misaligned: got err=%b cause=%0d rdata=%h expected 1/4/0", got_err, got_cause, got_rdata);
    end
    total++;
    if (got_lat !== 1 || r_cnt !== r0) begin
      bad++; $display("FAIL lh_misaligned_timing: got lat=%0d ren=%0d expected 1/0", got_lat, r_cnt - r0);
    end
    w0 = w_cnt;
    issue(1'b1, 3'b010, 32'h102, 32'hDEADBEEF);
    total++;
    if (got_err !== 1'b1 || got_cause !== 4'd6 || got_lat !== 1) begin
      bad++; $display("FAIL sw_misaligned: got err=%b cause=%0d lat=%0d expected 1/6/1", got_err, got_cause, got_lat);
    end
    total++;
    if (w_cnt !== w0 || mem[8'h40] !== 32'hAAFF7F01) begin
      bad++; $display("FAIL sw_misaligned_mem: got wen=%0d word=%h expected 0/aaff7f01", w_cnt - w0, mem[8'h40]);
    end
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    total++;
    if (got_err !== 1'b1 || got_cause !== 4'd2) begin
      bad++; $display("FAIL illegal_load: got err=%b cause=%0d expected 1/2", got_err, got_cause);
    end
    issue(1'b1, 3'b100, 32'h100, 32'h0);
    total++;
    if (got_err !== 1'b1 || got_cause !== 4'd2) begin
      bad++; $display("FAIL illegal_store: got err=%b cause=%0d expected 1/2", got_err, got_cause);
    end
  endtask

  task automatic test_fault();
    fault_arm = 1'b1;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    total++;
    if (got_err !== 1'b1 || got_cause !== 4'd5 || got_rdata !== 32'd0) begin
      bad++; $display("FAIL load_fault: got err=%b cause=%0d rdata=%h expected 1/5/0", got_err, got_cause, got_rdata);
    end
    issue(1'b1, 3'b010, 32'h100, 32'hAAFF7F01);
    total++;
    if (got_err !== 1'b1 || got_cause !== 4'd7) begin
      bad++; $display("FAIL store_fault: got err=%b cause=%0d expected 1/7", got_err, got_cause);
    end
    fault_arm = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int r0, waited;
    r0 = r_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    @(posedge clk); #1;
    req_funct3 = 3'b100;
    req_addr   = 32'h102;
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (waited !== 2) begin
      bad++; $display("FAIL bp_first_latency: got %0d expected 2", waited);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hAAFF7F01 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: got rv=%b rdata=%h err=%b rdy=%b expected 1/aaff7f01/0/0",
                        c, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    total++;
    if (r_cnt - r0 !== 1) begin
      bad++; $display("FAIL bp_no_second_issue: got %0d expected 1", r_cnt - r0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_after_handshake: got rv=%b rdy=%b expected 0/1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_second_accept: got rdy=%b expected 0", req_ready);
    end
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (waited !== 2 || resp_rdata !== 32'h000000FF) begin
      bad++; $display("FAIL bp_second_resp: got lat=%0d rdata=%h expected 2/000000ff", waited, resp_rdata);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({resp_valid, resp_err, resp_cause, mem_r_en, mem_w_en} !== 8'd0 ||
        resp_rdata !== 32'd0 || mem_r_addr !== 32'd0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_outputs: got rv=%b rdata=%h raddr=%h rdy=%b expected 0/0/0/1",
                      resp_valid, resp_rdata, mem_r_addr, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_release: got rdy=%b rv=%b expected 1/0", req_ready, resp_valid);
    end
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    total++;
    if (got_rdata !== 32'hAAFF7F01 || got_lat !== 2 || got_err !== 1'b0) begin
      bad++; $display("FAIL reset_mid_next_lw: got rdata=%h lat=%0d err=%b expected aaff7f01/2/0",
                      got_rdata, got_lat, got_err);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    test_reset();
    test_loads();
    test_store();
    test_misaligned();
    test_illegal();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
